// File: rtl/prog_lut_pkg.sv
// Shared types and constants for the programmable LUT evaluator.
package prog_lut_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2
    } lutState_t;

    // Truth-table width for an n-input function.
    function automatic int table_w(input int n);
        return 1 << n;
    endfunction

    // Golden tables, minterm 0 in the LSB.
    localparam logic [7:0]  EQ_AC_3 = 8'hB5;   // Y = A'C' + AC + AB'
    localparam logic [15:0] XNOR4   = 16'h9669; // 4-input even-ones

endpackage

// File: rtl/prog_lut_loader.sv
// Serial truth-table loader: shadow register, bit counter and commit pulse.
module prog_lut_loader
    import prog_lut_pkg::*;
#(
    parameter  int N_IN    = 4,
    localparam int TABLE_W = table_w(N_IN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfgValid,
    input  logic               cfgBit,
    input  logic               cfgReady,
    output logic [TABLE_W-1:0] newTable,
    output logic               commit,
    output logic               cfgDone
);

    logic [TABLE_W-1:0] shadow;
    logic [N_IN-1:0]    loadCnt;
    logic               handshake;

    assign handshake = cfgValid & cfgReady;
    assign commit    = handshake & (&loadCnt);

    // Complete table as it will look once the bit on the bus is stored,
    // so the last bit and the commit land on the same edge.
    always_comb begin
        newTable          = shadow;
        newTable[loadCnt] = cfgBit;
    end

    // Shadow write, counter advance and the registered commit pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            loadCnt <= '0;
            cfgDone <= 1'b0;
        end else begin
            cfgDone <= commit;
            if (handshake) begin
                shadow[loadCnt] <= cfgBit;
                loadCnt         <= commit ? '0 : loadCnt + N_IN'(1);
            end
        end
    end

endmodule

// File: rtl/prog_lut_eval.sv
// Run-time programmable N-input Boolean function with serial load and sweep.
module prog_lut_eval
    import prog_lut_pkg::*;
#(
    parameter  int N_IN    = 4,
    localparam int TABLE_W = table_w(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_ready,
    output logic            cfg_done,
    input  logic [N_IN-1:0] in_vec,
    input  logic            in_valid,
    output logic            y,
    output logic            y_valid,
    input  logic            sweep_start,
    output logic            sweep_busy,
    output logic            sweep_valid,
    output logic [N_IN-1:0] sweep_idx,
    output logic            sweep_y,
    output logic            sweep_done
);

    lutState_t          state;
    logic [TABLE_W-1:0] activeTable;
    logic [TABLE_W-1:0] newTable;
    logic [N_IN-1:0]    sweepCnt;
    logic               commit;
    logic               handshake;
    logic               sweepLast;

    assign cfg_ready = (state != SWEEP);
    assign handshake = cfg_valid & cfg_ready;
    assign sweepLast = &sweepCnt;

    prog_lut_loader #(
        .N_IN(N_IN)
    ) uLoader (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfgValid (cfg_valid),
        .cfgBit   (cfg_bit),
        .cfgReady (cfg_ready),
        .newTable (newTable),
        .commit   (commit),
        .cfgDone  (cfg_done)
    );

    // Control FSM, atomic table commit and sweep counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            activeTable <= '0;
            sweepCnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state <= LOAD;
                    end else if (sweep_start) begin
                        state    <= SWEEP;
                        sweepCnt <= '0;
                    end
                end
                LOAD: begin
                    if (commit) begin
                        state       <= IDLE;
                        activeTable <= newTable;
                    end
                end
                SWEEP: begin
                    if (sweepLast) begin
                        state    <= IDLE;
                        sweepCnt <= '0;
                    end else begin
                        sweepCnt <= sweepCnt + N_IN'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered evaluation; frozen while a sweep owns the table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= 1'b0;
            y_valid <= 1'b0;
        end else if (state != SWEEP) begin
            y       <= activeTable[in_vec];
            y_valid <= in_valid;
        end else begin
            y_valid <= 1'b0;
        end
    end

    // Sweep beats are decoded straight from state so a reset cuts them off at once.
    always_comb begin
        sweep_busy  = (state == SWEEP);
        sweep_valid = sweep_busy;
        sweep_idx   = sweepCnt;
        sweep_y     = sweep_busy & activeTable[sweepCnt];
        sweep_done  = sweep_busy & sweepLast;
    end

endmodule

// File: tb/tb_prog_lut_eval.sv
// Self-checking bench for prog_lut_eval (N_IN=3 and N_IN=4 instances).
module tb_prog_lut_eval;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic       c3Valid, c3Bit, c3Ready, c3Done;
    logic [2:0] in3;
    logic       in3Valid, y3, y3Valid;
    logic       sw3Start, sw3Busy, sw3Valid, sw3Y, sw3Done;
    logic [2:0] sw3Idx;

    logic       c4Valid, c4Bit, c4Ready, c4Done;
    logic [3:0] in4;
    logic       in4Valid, y4, y4Valid;
    logic       sw4Start, sw4Busy, sw4Valid, sw4Y, sw4Done;
    logic [3:0] sw4Idx;

    int total = 0;
    int bad   = 0;

    logic [7:0]  model3;
    logic [15:0] model4;

    logic [10:0] outs3;
    logic [11:0] outs4;
    assign outs3 = {y3, y3Valid, c3Done, sw3Valid, sw3Idx, sw3Y, sw3Done, sw3Busy, c3Ready};
    assign outs4 = {y4, y4Valid, c4Done, sw4Valid, sw4Idx, sw4Y, sw4Done, sw4Busy, c4Ready};

    prog_lut_eval #(.N_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(c3Valid), .cfg_bit(c3Bit), .cfg_ready(c3Ready), .cfg_done(c3Done),
        .in_vec(in3), .in_valid(in3Valid), .y(y3), .y_valid(y3Valid),
        .sweep_start(sw3Start), .sweep_busy(sw3Busy), .sweep_valid(sw3Valid),
        .sweep_idx(sw3Idx), .sweep_y(sw3Y), .sweep_done(sw3Done)
    );

    prog_lut_eval #(.N_IN(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(c4Valid), .cfg_bit(c4Bit), .cfg_ready(c4Ready), .cfg_done(c4Done),
        .in_vec(in4), .in_valid(in4Valid), .y(y4), .y_valid(y4Valid),
        .sweep_start(sw4Start), .sweep_busy(sw4Busy), .sweep_valid(sw4Valid),
        .sweep_idx(sw4Idx), .sweep_y(sw4Y), .sweep_done(sw4Done)
    );

    always #5 clk = ~clk;

    // Golden equations used as an independent reference.
    function automatic bit eqAc(input int idx);
        bit a, b, c;
        a = idx[2]; b = idx[1]; c = idx[0];
        return (!a && !c) || (a && c) || (a && !b);
    endfunction

    function automatic bit evenOnes4(input int idx);
        logic [3:0] v;
        v = 4'(idx);
        return ($countones(v) % 2) == 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        c3Valid = 0; c3Bit = 0; in3 = '0; in3Valid = 0; sw3Start = 0;
        c4Valid = 0; c4Bit = 0; in4 = '0; in4Valid = 0; sw4Start = 0;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic eval3(input int v, input bit vld);
        in3 = 3'(v); in3Valid = vld;
        step();
        total++;
        if (y3Valid !== vld) begin
            bad++; $display("FAIL eval3_valid in=%0d: got %b want %b", v, y3Valid, vld);
        end
        if (vld) begin
            total++;
            if (y3 !== model3[v]) begin
                bad++; $display("FAIL eval3_y in=%0d: got %b want %b", v, y3, model3[v]);
            end
        end
        in3Valid = 0;
    endtask

    task automatic test_reset();
        idleInputs();
        #1 rst_n = 1'b0;
        #3;
        total++;
        if (outs3 !== 11'b1) begin
            bad++; $display("FAIL reset_outs3: got %b want %b", outs3, 11'b1);
        end
        total++;
        if (outs4 !== 12'b1) begin
            bad++; $display("FAIL reset_outs4: got %b want %b", outs4, 12'b1);
        end
        model3 = '0; model4 = '0;
        releaseReset();
    endtask

    task automatic test_eval_after_reset();
        eval3(0, 1'b1);
        for (int i = 0; i < 6; i++) eval3($urandom_range(0, 7), 1'($urandom_range(0, 1)));
    endtask

    // Serial load into dut3 with cfg_valid held high; random evaluation rides along.
    task automatic load3(input logic [7:0] tbl, input bit fixIn0, input bit holdSweep);
        logic [7:0] old;
        int v;
        old = model3;
        for (int i = 0; i < 8; i++) begin
            c3Valid = 1; c3Bit = tbl[i]; sw3Start = holdSweep;
            v = fixIn0 ? 0 : $urandom_range(0, 7);
            in3 = 3'(v); in3Valid = 1;
            total++;
            if (c3Ready !== 1'b1) begin
                bad++; $display("FAIL load3_ready bit=%0d: got %b want 1", i, c3Ready);
            end
            step();
            total++;
            if (y3 !== old[v] || y3Valid !== 1'b1) begin
                bad++; $display("FAIL load3_old_table bit=%0d in=%0d: got y=%b v=%b want y=%b v=1", i, v, y3, y3Valid, old[v]);
            end
            total++;
            if (c3Done !== 1'(i == 7)) begin
                bad++; $display("FAIL load3_done bit=%0d: got %b want %b", i, c3Done, 1'(i == 7));
            end
            total++;
            if (sw3Valid !== 1'b0 || sw3Busy !== 1'b0) begin
                bad++; $display("FAIL load3_no_sweep bit=%0d: got valid=%b busy=%b want 0", i, sw3Valid, sw3Busy);
            end
        end
        c3Valid = 0; sw3Start = 0;
        model3 = tbl;
        v = fixIn0 ? 0 : $urandom_range(0, 7);
        in3 = 3'(v);
        step();
        total++;
        if (y3 !== tbl[v]) begin
            bad++; $display("FAIL load3_new_table in=%0d: got %b want %b", v, y3, tbl[v]);
        end
        total++;
        if (c3Done !== 1'b0) begin
            bad++; $display("FAIL load3_done_pulse: got %b want 0", c3Done);
        end
        in3Valid = 0;
    endtask

    // Full sweep of dut3; optionally also checks against the golden equation.
    task automatic sweep3(input bit golden);
        int v0;
        logic hold;
        v0 = $urandom_range(0, 7);
        in3 = 3'(v0); in3Valid = 0; sw3Start = 1;
        step();
        sw3Start = 0;
        hold = model3[v0];
        for (int k = 0; k < 8; k++) begin
            in3 = 3'($urandom_range(0, 7)); in3Valid = 1;
            total++;
            if (sw3Valid !== 1'b1 || sw3Busy !== 1'b1 || c3Ready !== 1'b0) begin
                bad++; $display("FAIL sweep_flags k=%0d: got valid=%b busy=%b ready=%b want 1 1 0", k, sw3Valid, sw3Busy, c3Ready);
            end
            total++;
            if (sw3Idx !== 3'(k)) begin
                bad++; $display("FAIL sweep_idx k=%0d: got %0d want %0d", k, sw3Idx, k);
            end
            total++;
            if (sw3Y !== model3[k]) begin
                bad++; $display("FAIL sweep_y k=%0d: got %b want %b", k, sw3Y, model3[k]);
            end
            if (golden) begin
                total++;
                if (sw3Y !== eqAc(k)) begin
                    bad++; $display("FAIL sweep_golden k=%0d: got %b want %b", k, sw3Y, eqAc(k));
                end
            end
            total++;
            if (sw3Done !== 1'(k == 7)) begin
                bad++; $display("FAIL sweep_done k=%0d: got %b want %b", k, sw3Done, 1'(k == 7));
            end
            total++;
            if (y3Valid !== 1'b0 || y3 !== hold) begin
                bad++; $display("FAIL sweep_eval_frozen k=%0d: got y=%b v=%b want y=%b v=0", k, y3, y3Valid, hold);
            end
            step();
        end
        in3Valid = 0;
        total++;
        if (sw3Busy !== 1'b0 || sw3Valid !== 1'b0 || sw3Done !== 1'b0 || c3Ready !== 1'b1) begin
            bad++; $display("FAIL sweep_end: got busy=%b valid=%b done=%b ready=%b want 0 0 0 1", sw3Busy, sw3Valid, sw3Done, c3Ready);
        end
    endtask

    task automatic test_load_eval3();
        load3(8'hB5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            int v;
            v = (i == 0) ? 0 : (i == 1) ? 1 : (i == 2) ? 6 : 7;
            in3 = 3'(v); in3Valid = 1;
            step();
            total++;
            if (y3 !== eqAc(v) || y3Valid !== 1'b1) begin
                bad++; $display("FAIL golden_eval in=%0d: got y=%b v=%b want y=%b v=1", v, y3, y3Valid, eqAc(v));
            end
        end
        in3Valid = 0;
    endtask

    task automatic test_sweep();
        sweep3(1'b1);
    endtask

    // N_IN=4 load with cfg_valid toggling every other cycle.
    task automatic test_load4_toggle();
        logic [15:0] tbl, old;
        int h, cyc, v;
        bit hsNow;
        tbl = 16'h9669; old = model4; h = 0; cyc = 0;
        while (h < 16 && cyc < 64) begin
            c4Valid = (cyc % 2 == 0); c4Bit = tbl[h % 16];
            v = $urandom_range(0, 15); in4 = 4'(v); in4Valid = 1;
            hsNow = c4Valid && c4Ready;
            step();
            if (hsNow) h++;
            total++;
            if (c4Done !== 1'(hsNow && h == 16)) begin
                bad++; $display("FAIL load4_done hs=%0d cyc=%0d: got %b want %b", h, cyc, c4Done, 1'(hsNow && h == 16));
            end
            total++;
            if (y4 !== old[v]) begin
                bad++; $display("FAIL load4_old_table in=%0d: got %b want %b", v, y4, old[v]);
            end
            cyc++;
        end
        c4Valid = 0;
        total++;
        if (h != 16) begin
            bad++; $display("FAIL load4_budget: got %0d handshakes want 16", h);
        end
        model4 = tbl;
        for (int i = 0; i < 6; i++) begin
            v = (i == 0) ? 15 : (i == 1) ? 7 : $urandom_range(0, 15);
            in4 = 4'(v); in4Valid = 1;
            step();
            total++;
            if (y4 !== evenOnes4(v) || y4Valid !== 1'b1) begin
                bad++; $display("FAIL load4_eval in=%0d: got y=%b v=%b want y=%b v=1", v, y4, y4Valid, evenOnes4(v));
            end
        end
        in4Valid = 0;
    endtask

    task automatic test_commit_boundary();
        load3(8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_start_conflict();
        load3(8'hB5, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        load3(8'($urandom()), 1'b0, 1'b0);
        load3(8'($urandom()), 1'b0, 1'b0);
        sweep3(1'b0);
        sweep3(1'b0);
        load3(8'hB5, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 4; i++) begin
            c3Valid = 1; c3Bit = 1'($urandom_range(0, 1));
            step();
        end
        c3Valid = 0;
        rst_n = 1'b0;
        #2;
        total++;
        if (outs3 !== 11'b1) begin
            bad++; $display("FAIL reset_mid_load: got %b want %b", outs3, 11'b1);
        end
        model3 = '0; model4 = '0;
        releaseReset();
        for (int v = 0; v < 8; v++) eval3(v, 1'b1);
        load3(8'($urandom()) | 8'h01, 1'b0, 1'b0);
        for (int v = 0; v < 8; v++) eval3(v, 1'b1);
    endtask

    task automatic test_reset_mid_sweep();
        load3(8'hB5, 1'b0, 1'b0);
        sw3Start = 1;
        step();
        sw3Start = 0;
        for (int k = 0; k < 3; k++) step();
        total++;
        if (sw3Idx !== 3'd3 || sw3Valid !== 1'b1) begin
            bad++; $display("FAIL reset_sweep_pos: got idx=%0d valid=%b want 3 1", sw3Idx, sw3Valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (outs3 !== 11'b1) begin
            bad++; $display("FAIL reset_mid_sweep: got %b want %b", outs3, 11'b1);
        end
        model3 = '0; model4 = '0;
        releaseReset();
        for (int k = 0; k < 10; k++) begin
            total++;
            if (sw3Done !== 1'b0 || sw3Valid !== 1'b0) begin
                bad++; $display("FAIL reset_sweep_aborted c=%0d: got done=%b valid=%b want 0 0", k, sw3Done, sw3Valid);
            end
            step();
        end
        for (int v = 0; v < 8; v++) eval3(v, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_eval_after_reset();
        test_load_eval3();
        test_sweep();
        test_load4_toggle();
        test_commit_boundary();
        test_start_conflict();
        test_back_to_back();
        test_reset_mid_load();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_lut_eval.md
Name: prog_lut_eval

Overview:
- Run-time programmable N-input Boolean function block, the parametrised successor to the team's fixed gate-level and operator implementations of 3- and 4-input functions.
- The truth table is loaded serially through a valid/ready handshake into a shadow register and committed atomically.
- Inputs are evaluated with a registered output.
- A built-in sweep mode walks all 2^N_IN minterms and streams the active table out for self-check against the golden equations.

Parameters:
- N_IN, default 4: number of function inputs; legal range 2..6.
- TABLE_W, default 2**N_IN: truth-table width in bits. Derived; must not be overridden.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- cfg_valid, input, 1: a configuration bit is presented.
- cfg_bit, input, 1: table bit. Minterm 0 first, minterm TABLE_W-1 last.
- cfg_ready, output, 1: block accepts a configuration bit.
- cfg_done, output, 1: one-cycle pulse when a new table is committed.
- in_vec, input, N_IN: function inputs. MSB is variable A; the minterm index equals in_vec.
- in_valid, input, 1: evaluate in_vec this cycle.
- y, output, 1: registered function result.
- y_valid, output, 1: y is valid this cycle.
- sweep_start, input, 1: request an exhaustive sweep.
- sweep_busy, output, 1: sweep in progress.
- sweep_valid, output, 1: sweep_idx/sweep_y valid.
- sweep_idx, output, N_IN: minterm index being reported.
- sweep_y, output, 1: active table bit at sweep_idx.
- sweep_done, output, 1: one-cycle pulse on the last sweep beat.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Active table, shadow table, load counter and sweep counter all go to 0.
  - State goes to IDLE.
  - y, y_valid, cfg_done, sweep_valid, sweep_idx, sweep_y, sweep_done and sweep_busy all go to 0.
  - cfg_ready goes to 1.
- FSM states are IDLE, LOAD and SWEEP.
- IDLE:
  - A handshake (cfg_valid & cfg_ready) stores cfg_bit at shadow[0], sets load_cnt=1 and moves to LOAD.
  - If sweep_start arrives without a handshake, go to SWEEP.
  - If a handshake and sweep_start arrive in the same cycle, the configuration bit wins and sweep_start is dropped.
- LOAD:
  - cfg_ready=1.
  - Each handshake writes shadow[load_cnt] and increments load_cnt.
  - cfg_valid low stalls the load with no timeout.
  - sweep_start is ignored.
  - On the handshake of bit TABLE_W-1: next edge copies shadow to active, pulses cfg_done and returns to IDLE. The counter clears.
- SWEEP:
  - cfg_ready=0 and sweep_busy=1.
  - Counter runs 0..TABLE_W-1, one beat per cycle: sweep_valid=1, sweep_idx=cnt, sweep_y=active[cnt].
  - sweep_done is asserted with the beat at cnt=TABLE_W-1; next state is IDLE.
  - sweep_start arriving during SWEEP is ignored.
- Evaluation:
  - In IDLE and LOAD: y <= active[in_vec], y_valid <= in_valid. Latency is 1 cycle; one result per cycle.
  - While in LOAD, evaluation uses the old table until the commit edge. A result sampled on the commit edge uses the old table; the following cycle uses the new one.
  - In SWEEP, in_valid is ignored and y_valid=0. y holds its last value.
- Sweep timing: sweep_start sampled at edge t gives the first beat in cycle t+1 and the sweep_done beat in cycle t+TABLE_W.
- Reset mid-LOAD discards the partial shadow and clears the active table. Reset mid-SWEEP aborts immediately with no sweep_done.
- Back-to-back:
  - A new load may begin in the cycle after cfg_done.
  - A sweep may begin in the cycle after sweep_done.

Decomposition:
- Package prog_lut_pkg holds:
  - the state enum (IDLE, LOAD, SWEEP);
  - the function table_w(n) = 2**n;
  - golden table constants, with the minterm-0 bit as LSB: EQ_AC_3 = 8'hB5 for Y=A'C'+AC+AB', and XNOR4 = 16'h9669 for the 4-input even-ones function.
- One sub-module, prog_lut_loader, holds the shadow register, load counter, handshake and commit pulse.
- The top level holds the FSM, active table, evaluation register and sweep counter.

Test Plan:
1. N_IN=3: after reset, present in_vec=3'b000 with in_valid -> y=0, y_valid=1 one cycle later. Then load 8'hB5 with cfg_valid held high -> cfg_done exactly 8 cycles after the first accepted bit. Then in_vec=0,1,6,7 -> y=1,0,0,1.
2. N_IN=3 with 8'hB5 loaded: pulse sweep_start -> 8 beats, sweep_idx 0..7, sweep_y=1,0,1,0,1,1,0,1, sweep_done on idx 7, sweep_busy low the next cycle.
3. N_IN=4: load 16'h9669 with cfg_valid toggling every other cycle -> cfg_done after 16 handshakes. in_vec=4'b1111 -> y=1; in_vec=4'b0111 -> y=0.
4. N_IN=3 with 8'hB5 active: reload with 8'h00 while driving in_vec=0 continuously -> y=1 through the commit cycle, then y=0 from the next cycle.
5. Drive cfg_valid and sweep_start together in IDLE -> LOAD entered, no sweep beats. Assert sweep_start during LOAD -> ignored.
6. Assert rst_n low after 4 of 8 bits, and again mid-sweep at idx 3 -> all outputs 0 immediately, no sweep_done. After release, y=0 for every in_vec.
